// File: rtl/hazard_sequencer.sv
// hazard_sequencer: operand forwarding, load-use and memory-wait stall control,
// branch flush control, a memory-wait timeout FSM and saturating perf counters
// for the 5-stage RISC-V pipeline.
//
// Handshake: the data memory is a req/ready pair. A cycle with MemReqM=1 and
// MemReadyM=0 is a wait cycle. The access completes on the first cycle that
// MemReadyM=1. There is no valid/ready back-pressure toward the memory; this block
// only holds the pipeline while it waits. DbgWait exposes the FSM state
// (0 = RUN, 1 = WAIT).
module hazard_sequencer #(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              ResultSrcE0,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemTimeout,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushCount,
  output logic              DbgWait
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] TO_VAL  = WCW'(TIMEOUT);
  localparam logic [WCW-1:0] CNT_ONE = WCW'(1);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       r_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [0:0]       w_state_nxt;
  logic [WCW-1:0]   w_wait_cnt_nxt;
  logic             w_timeout_hit;
  logic             w_mem_stall;
  logic             w_lw_stall;

  // Load in E whose destination feeds a source in D must wait one cycle.
  assign w_lw_stall = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  // Memory-wait FSM next state. The first wait cycle is seen in RUN, so WAIT
  // starts counting at 1. A timeout abandons the access and resumes the pipe.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_hit  = 1'b0;
    w_mem_stall    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (MemReqM && !MemReadyM) begin
          w_mem_stall    = 1'b1;
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = CNT_ONE;
        end
      end
      S_WAIT: begin
        if (MemReadyM) begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == TO_VAL) begin
          w_timeout_hit  = 1'b1;
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_mem_stall    = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt    = S_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Forwarding selects and stall/flush outputs; reset forces a flushed, unstalled pipe.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (!reset) begin
      if ((Rs1E != '0) && (Rs1E == RdM) && RegWriteM)      ForwardAE = 2'b10;
      else if ((Rs1E != '0) && (Rs1E == RdW) && RegWriteW) ForwardAE = 2'b01;
      if ((Rs2E != '0) && (Rs2E == RdM) && RegWriteM)      ForwardBE = 2'b10;
      else if ((Rs2E != '0) && (Rs2E == RdW) && RegWriteW) ForwardBE = 2'b01;
      if (w_mem_stall) begin
        // E is frozen, so load-use and branch resolution are re-evaluated later.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end else begin
        StallF = w_lw_stall;
        StallD = w_lw_stall;
        FlushD = PCSrcE;
        FlushE = w_lw_stall || PCSrcE;
        FlushW = 1'b0;
      end
    end
  end

  // FSM, wait counter, sticky timeout flag and saturating perf counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout_hit) r_timeout <= 1'b1;
      if (StallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (PCSrcE && !w_mem_stall && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign MemTimeout  = r_timeout;
  assign StallCycles = r_stall_cnt;
  assign FlushCount  = r_flush_cnt;
  assign DbgWait     = (r_state == S_WAIT);

endmodule
